// File: rtl/suma_serial.sv
// Bit-serial M-bit adder: one full adder plus a carry flop, LSB first, with
// start/busy/done handshake and held result/flag registers for the ALU mux.
module suma_serial #(
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] R,
    output logic         C,
    output logic         V,
    output logic         N,
    output logic         Z
);

    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [M-1:0]  a_sh_q, a_sh_d;
    logic [M-1:0]  b_sh_q, b_sh_d;
    logic [M-1:0]  sum_sh_q, sum_sh_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [M-1:0]  r_q, r_d;
    logic          cf_q, cf_d;
    logic          vf_q, vf_d;
    logic          nf_q, nf_d;
    logic          zf_q, zf_d;

    logic          s_bit;
    logic          cout;
    logic [M-1:0]  sum_full;
    logic          last_bit;

    // Full adder on the operand LSBs and the assembled sum including this bit.
    always_comb begin
        s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        cout     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        sum_full = {s_bit, sum_sh_q[M-1:1]};
        last_bit = (cnt_q == CW'(M - 1));
    end

    // Next-state logic for the sequencer, datapath shifters and held results.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        r_d      = r_q;
        cf_d     = cf_q;
        vf_d     = vf_q;
        nf_d     = nf_q;
        zf_d     = zf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_sh_d  = A;
                    b_sh_d  = B;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_full;
                c_d      = cout;
                if (last_bit) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    r_d     = sum_full;
                    cf_d    = cout;
                    // c_q is the carry into the MSB on this final step
                    vf_d    = c_q ^ cout;
                    nf_d    = s_bit;
                    zf_d    = (sum_full == '0);
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                // start is deliberately not sampled here
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            r_q      <= '0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
            nf_q     <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            r_q      <= r_d;
            cf_q     <= cf_d;
            vf_q     <= vf_d;
            nf_q     <= nf_d;
            zf_q     <= zf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;
    assign C    = cf_q;
    assign V    = vf_q;
    assign N    = nf_q;
    assign Z    = zf_q;

endmodule
